// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad hex entry block
//
// Purpose : state and scan-result encodings, key map and default timing
//           constants used by keypad_scanner and keypad_hex_entry.
// Ports   : none (package).
package keypad_pkg;

   localparam int SCAN_DIV_DEFAULT       = 10000;
   localparam int DEBOUNCE_SCANS_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   // Number of keys seen during one full scan; MULTI means "more than one".
   typedef enum logic [1:0] {
      NKEYS_NONE  = 2'd0,
      NKEYS_ONE   = 2'd1,
      NKEYS_MULTI = 2'd2
   } nkeys_t;

   // Hex code per key, indexed {row, col}; row 0 is the top row.
   // Bottom row: '*' -> E, '0' -> 0, '#' -> F, 'D' -> D.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage

// File: rtl/keypad_hex_entry_if.sv
// rtl/keypad_hex_entry_if.sv - keypad pins and digit-entry outputs of keypad_hex_entry
//
// Purpose : bundles the keypad matrix lines, the clear input and the entry
//           outputs. Names carry the direction as seen by keypad_hex_entry.
// Signals : i_rows[3:0]     keypad rows, active-low, asynchronous
//           i_clear         synchronous clear of the entry register
//           o_cols[3:0]     column drive, one bit low at a time
//           o_value[15:0]   entered digits, newest in [3:0]
//           o_key_code[3:0] code of the most recently accepted key
//           o_key_valid     one-cycle pulse per accepted key
// Modports: slave  - keypad_hex_entry side
//           master - keypad / system side
interface keypad_hex_entry_if;

   logic [3:0]  i_rows;
   logic        i_clear;
   logic [3:0]  o_cols;
   logic [15:0] o_value;
   logic [3:0]  o_key_code;
   logic        o_key_valid;

   modport slave (
      input  i_rows,
      input  i_clear,
      output o_cols,
      output o_value,
      output o_key_code,
      output o_key_valid
   );

   modport master (
      output i_rows,
      output i_clear,
      input  o_cols,
      input  o_value,
      input  o_key_code,
      input  o_key_valid
   );

endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with per-scan key summary
//
// Purpose : synchronises the row lines, drives one column low per slot of
//           SCAN_DIV clocks, samples the rows at the end of each slot and,
//           after the column-3 sample, reports how many keys were down and
//           the code of the single key (if exactly one).
// Ports   : i_clk          system clock
//           i_rst_n        asynchronous active-low reset
//           i_rows[3:0]    raw keypad rows, active-low
//           o_cols[3:0]    column drive, ~(1 << index)
//           o_scan_done    one-cycle strobe after the column-3 sample
//           o_nkeys        keys seen in the completed scan (valid with o_scan_done)
//           o_code[3:0]    key code when o_nkeys == NKEYS_ONE
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEFAULT
)
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_rows,
   output logic [3:0] o_cols,
   output logic       o_scan_done,
   output nkeys_t     o_nkeys,
   output logic [3:0] o_code
);

   localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [3:0]    r_rows_meta;
   logic [3:0]    r_rows_sync;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_col;
   logic [3:0]    r_cols;
   nkeys_t        r_acc_n;
   logic [3:0]    r_acc_code;
   logic          r_scan_done;
   nkeys_t        r_nkeys;
   logic [3:0]    r_code;

   logic          w_slot_end;
   logic [2:0]    w_hits;
   logic [3:0]    w_slot_code;
   nkeys_t        w_base_n;
   nkeys_t        w_next_n;
   logic [3:0]    w_next_code;

   assign w_slot_end = (r_presc == PRESC_LAST);

   // Rows pulled low in the current column; the code only matters when one is low.
   always_comb begin
      w_hits      = 3'd0;
      w_slot_code = 4'h0;
      for (int r = 3; r >= 0; r--) begin
         if (!r_rows_sync[r]) begin
            w_hits      = w_hits + 3'd1;
            w_slot_code = key_lookup(2'(r), r_col);
         end
      end
   end

   // Merge this slot into the running scan total; column 0 starts a fresh scan.
   always_comb begin
      w_base_n    = (r_col == 2'd0) ? NKEYS_NONE : r_acc_n;
      w_next_n    = w_base_n;
      w_next_code = r_acc_code;
      if (w_hits > 3'd1) begin
         w_next_n = NKEYS_MULTI;
      end else if (w_hits == 3'd1) begin
         if (w_base_n == NKEYS_NONE) begin
            w_next_n    = NKEYS_ONE;
            w_next_code = w_slot_code;
         end else begin
            w_next_n = NKEYS_MULTI;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rows_meta <= 4'hF;
         r_rows_sync <= 4'hF;
         r_presc     <= '0;
         r_col       <= 2'd0;
         r_cols      <= 4'b1110;
         r_acc_n     <= NKEYS_NONE;
         r_acc_code  <= 4'h0;
         r_scan_done <= 1'b0;
         r_nkeys     <= NKEYS_NONE;
         r_code      <= 4'h0;
      end else begin
         r_rows_meta <= i_rows;
         r_rows_sync <= r_rows_meta;
         r_scan_done <= 1'b0;
         if (w_slot_end) begin
            r_presc    <= '0;
            r_col      <= r_col + 2'd1;
            r_cols     <= ~(4'b0001 << (r_col + 2'd1));
            r_acc_n    <= w_next_n;
            r_acc_code <= w_next_code;
            if (r_col == 2'd3) begin
               r_scan_done <= 1'b1;
               r_nkeys     <= w_next_n;
               r_code      <= w_next_code;
            end
         end else begin
            r_presc <= r_presc + PW'(1);
         end
      end
   end

   assign o_cols      = r_cols;
   assign o_scan_done = r_scan_done;
   assign o_nkeys     = r_nkeys;
   assign o_code      = r_code;

endmodule

// File: rtl/keypad_hex_entry.sv
// rtl/keypad_hex_entry.sv - debounced 4x4 keypad to 16-bit hex entry register
//
// Purpose : debounces the per-scan results from keypad_scanner, emits one
//           key_valid pulse per accepted press and shifts the digit into a
//           16-bit value (newest digit in [3:0]).
// Ports   : i_clk    system clock (10 MHz)
//           i_rst_n  asynchronous active-low reset
//           kp_bus   keypad_hex_entry_if.slave (rows, clear, cols, value,
//                    key_code, key_valid)
module keypad_hex_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
   parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
)
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   keypad_hex_entry_if.slave     kp_bus
);

   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_cand;
   logic [3:0]  r_key_code;
   logic        r_key_valid;
   logic [15:0] r_value;

   logic [3:0]  w_cols;
   logic        w_scan_done;
   nkeys_t      w_nkeys;
   logic [3:0]  w_code;

   state_t      w_state_nxt;
   logic [3:0]  w_cnt_nxt;
   logic [3:0]  w_cand_nxt;
   logic        w_accept;
   logic [3:0]  w_accept_code;

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rows      (kp_bus.i_rows),
      .o_cols      (w_cols),
      .o_scan_done (w_scan_done),
      .o_nkeys     (w_nkeys),
      .o_code      (w_code)
   );

   // The FSM only moves on a completed scan.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cand_nxt    = r_cand;
      w_accept      = 1'b0;
      w_accept_code = r_cand;
      if (w_scan_done) begin
         case (r_state)
            S_IDLE: begin
               if (w_nkeys == NKEYS_ONE) begin
                  w_cand_nxt = w_code;
                  if (DEB_LAST <= 4'd1) begin
                     // Single-scan debounce accepts on the first sighting.
                     w_accept      = 1'b1;
                     w_accept_code = w_code;
                     w_state_nxt   = S_HELD;
                     w_cnt_nxt     = 4'd0;
                  end else begin
                     w_state_nxt = S_DEBOUNCE;
                     w_cnt_nxt   = 4'd1;
                  end
               end
            end
            S_DEBOUNCE: begin
               if (w_nkeys == NKEYS_ONE && w_code == r_cand) begin
                  if (r_cnt + 4'd1 >= DEB_LAST) begin
                     w_accept    = 1'b1;
                     w_state_nxt = S_HELD;
                     w_cnt_nxt   = 4'd0;
                  end else begin
                     w_cnt_nxt = r_cnt + 4'd1;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = 4'd0;
               end
            end
            S_HELD: begin
               if (w_nkeys == NKEYS_NONE) begin
                  if (DEB_LAST <= 4'd1) begin
                     w_state_nxt = S_IDLE;
                     w_cnt_nxt   = 4'd0;
                  end else begin
                     w_state_nxt = S_RELEASE;
                     w_cnt_nxt   = 4'd1;
                  end
               end
            end
            S_RELEASE: begin
               if (w_nkeys == NKEYS_NONE) begin
                  if (r_cnt + 4'd1 >= DEB_LAST) begin
                     w_state_nxt = S_IDLE;
                     w_cnt_nxt   = 4'd0;
                  end else begin
                     w_cnt_nxt = r_cnt + 4'd1;
                  end
               end else begin
                  // Release bounce: back to held without a new event.
                  w_state_nxt = S_HELD;
                  w_cnt_nxt   = 4'd0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_cand      <= 4'h0;
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
         r_value     <= 16'h0000;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cand      <= w_cand_nxt;
         r_key_valid <= w_accept;
         if (w_accept) begin
            r_key_code <= w_accept_code;
         end
         // Clear wins over the old contents but still keeps a same-cycle digit.
         if (kp_bus.i_clear) begin
            r_value <= w_accept ? {12'h000, w_accept_code} : 16'h0000;
         end else if (w_accept) begin
            r_value <= {r_value[11:0], w_accept_code};
         end
      end
   end

   assign kp_bus.o_cols      = w_cols;
   assign kp_bus.o_value     = r_value;
   assign kp_bus.o_key_code  = r_key_code;
   assign kp_bus.o_key_valid = r_key_valid;

endmodule
